gem_ext_fifo_rx: RTL and testbench
==================================

// Module: gem_ext_fifo_rx
// PURPOSE
//  Receive side of the MPSoC GEM External FIFO interface. Accepts the GEM rx_w_* byte write
//  strobes (no backpressure possible), buffers them in a small internal FIFO and presents
//  frames as an 8-bit AXI-Stream master, normally feeding a frame FIFO (axis_fifo, FRAME_FIFO=1).
//  Marks aborted, errored or overflowed frames with tuser=1 so downstream drops them.
// PARAMETERS
//  DEPTH   16  internal buffer entries, power of 2, >=4; one entry reserved for frame terminators
// PORTS
//  clk                  in   1   single clock for GEM FIFO side and AXIS side
//  rstn                 in   1   asynchronous active-low reset
//  gem_rx_w_data        in   8   receive byte
//  gem_rx_w_wr          in   1   byte write strobe, one byte per cycle when high
//  gem_rx_w_sop         in   1   start of frame, qualified by gem_rx_w_wr
//  gem_rx_w_eop         in   1   end of frame, qualified by gem_rx_w_wr (same cycle as last byte)
//  gem_rx_w_err         in   1   frame error, sampled with eop
//  gem_rx_w_flush       in   1   GEM flush request, level
//  gem_rx_w_overflow    out  1   buffer overflow indication to GEM
//  m_axis_tdata         out  8   stream data
//  m_axis_tvalid        out  1   stream valid
//  m_axis_tready        in   1   stream ready
//  m_axis_tlast         out  1   last byte of frame
//  m_axis_tuser         out  1   1 = bad frame (err, overflow, abort, flush)
// BEHAVIOUR
//  - Reset: all outputs 0, buffer empty, state IDLE. Reset mid-frame discards everything; no tlast.
//  - Buffer entry = {user,last,data[7:0]}; write in cycle N -> m_axis_tvalid in N+1 (registered).
//  - AXIS: pop on tvalid&tready; tdata/tlast/tuser stable while tvalid&!tready. Read+write same
//    cycle: count unchanged. count is $clog2(DEPTH)+1 bits, never wraps.
//  - Data write (tlast=0) allowed only when count<DEPTH-1; writes with tlast=1 may use reserved slot.
//  - FSM:
//    IDLE: wr&sop -> write byte (tlast=eop, tuser=eop&err); -> RECV unless eop. wr&!sop ignored.
//    RECV: wr&!sop&!eop: room -> write byte; no room -> drop byte, -> DROP.
//          wr&eop: write byte tlast=1, tuser=err -> IDLE.
//          wr&sop (missing eop): write byte tlast=1,tuser=1 -> DISCARD (new frame sacrificed).
//          flush: write terminator {user=1,last=1,data=0} -> IDLE.
//    DROP: wr ignored; on wr&eop or flush write terminator {1,1,8'h00} -> IDLE.
//    DISCARD: wr ignored, no write; wr&eop or flush -> IDLE.
//  - flush in IDLE: no effect. flush has priority over wr in the same cycle (byte dropped).
//  - gem_rx_w_overflow: registered, 1 from cycle after first dropped byte until cycle after exit
//    from DROP; 0 otherwise.
//  - Terminator always fits: reserved slot guaranteed free because data writes stop at DEPTH-1.
//  - Output frames always end with tlast=1; any tuser=1 marks only the tlast beat.
// CONFIGURATION
//  GEM_EXT_FIFO_RX_STATUS_EN defined: adds ports gem_rx_w_status in 45, rx_status out 45,
//    rx_status_valid out 1; status captured on every accepted wr&eop (RECV or IDLE sop&eop),
//    rx_status_valid pulses 1 cycle one cycle later; reset 0.
//  Not defined: ports absent, gem_rx_w_status not connected, no status logic.
// TESTING
//  1. 64-byte frame 00..3F, err=0, tready=1 -> 64 beats, tlast on 3F, tuser=0, overflow=0.
//  2. Same frame, err=1 at eop -> identical data, tlast beat tuser=1.
//  3. tready=0, 40-byte frame, DEPTH=16 -> 15 bytes buffered, overflow=1 from byte 16+1 cycle,
//     then tready=1 -> 15 data beats + terminator {00,last,user}; overflow 0 after eop.
//  4. Frame A 10 bytes, then sop without eop, then frame B eop -> A ends tlast,tuser=1 on
//     11th beat (B's first byte); B dropped; next good frame passes cleanly.
//  5. flush after 5 bytes of frame -> 5 beats + terminator tuser=1; flush in IDLE -> no beat.
//  6. rstn low mid-frame with data buffered -> tvalid=0 immediately; following frame intact.
//     With GEM_EXT_FIFO_RX_STATUS_EN: status 45'h1234 at eop -> rx_status=1234, valid 1-cycle pulse.

Source files
------------

// File: rtl/gem_ext_fifo_rx.sv
`timescale 1ns/1ps
// gem_ext_fifo_rx
// Receive side of the GEM External FIFO interface. GEM byte writes (no backpressure)
// are buffered in a small FIFO and presented as an 8-bit AXI-Stream master. Frames that
// are aborted, errored, flushed or overflowed end with a tlast beat carrying tuser=1.
//
// Ports:
//   clk, rstn              single clock, asynchronous active-low reset
//   gem_rx_w_data/wr       GEM byte write (one byte per cycle while wr is high)
//   gem_rx_w_sop/eop/err   frame delimiters and error flag, qualified by wr
//   gem_rx_w_flush         GEM flush request (level)
//   gem_rx_w_overflow      high while bytes of the current frame are being dropped
//   m_axis_*               AXI-Stream master (tdata/tvalid/tready/tlast/tuser)
//
// Optional feature (macro GEM_EXT_FIFO_RX_STATUS_EN): adds gem_rx_w_status input and
// rx_status/rx_status_valid outputs; status is captured on each accepted end of frame.
module gem_ext_fifo_rx #(
  parameter int unsigned DEPTH = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  gem_rx_w_data,
  input  logic        gem_rx_w_wr,
  input  logic        gem_rx_w_sop,
  input  logic        gem_rx_w_eop,
  input  logic        gem_rx_w_err,
  input  logic        gem_rx_w_flush,
  output logic        gem_rx_w_overflow,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser
`ifdef GEM_EXT_FIFO_RX_STATUS_EN
  ,
  input  logic [44:0] gem_rx_w_status,
  output logic [44:0] rx_status,
  output logic        rx_status_valid
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic       user;
    logic       last;
    logic [7:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECV,
    ST_DROP,
    ST_DISCARD
  } state_t;

  localparam entry_t TERM = '{user: 1'b1, last: 1'b1, data: 8'h00};

  state_t           state_q, state_d;
  entry_t           mem_q [DEPTH];
  entry_t           head_q, head_d;
  entry_t           wr_entry;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q;
  logic             ovf_q;
  logic             push;
  logic             pop;
  logic             room_data;
  logic             room_last;
  logic             eop_accept;

  // Data bytes stop one short of full so a terminator always has a slot.
  assign room_data = (count_q < CNT_W'(DEPTH - 1));
  assign room_last = (count_q < CNT_W'(DEPTH));
  assign pop       = valid_q & m_axis_tready;

  // Frame FSM: decides what (if anything) is written into the buffer this cycle.
  always_comb begin
    state_d    = state_q;
    push       = 1'b0;
    wr_entry   = TERM;
    eop_accept = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Flush wins over a simultaneous write; in IDLE it simply drops that byte.
        if (!gem_rx_w_flush && gem_rx_w_wr && gem_rx_w_sop) begin
          if (gem_rx_w_eop) begin
            // Single-byte frame; lost whole if even the terminator slot is taken.
            if (room_last) begin
              push       = 1'b1;
              wr_entry   = '{user: gem_rx_w_err, last: 1'b1, data: gem_rx_w_data};
              eop_accept = 1'b1;
            end
          end else if (room_data) begin
            push     = 1'b1;
            wr_entry = '{user: 1'b0, last: 1'b0, data: gem_rx_w_data};
            state_d  = ST_RECV;
          end else begin
            // Nothing of this frame was written, so it is skipped silently.
            state_d = ST_DISCARD;
          end
        end
      end
      ST_RECV: begin
        if (gem_rx_w_flush) begin
          push    = 1'b1;
          state_d = ST_IDLE;
        end else if (gem_rx_w_wr) begin
          if (gem_rx_w_sop) begin
            // Missing eop: the new frame's first byte closes the old one as bad.
            push     = 1'b1;
            wr_entry = '{user: 1'b1, last: 1'b1, data: gem_rx_w_data};
            state_d  = gem_rx_w_eop ? ST_IDLE : ST_DISCARD;
          end else if (gem_rx_w_eop) begin
            push       = 1'b1;
            wr_entry   = '{user: gem_rx_w_err, last: 1'b1, data: gem_rx_w_data};
            eop_accept = 1'b1;
            state_d    = ST_IDLE;
          end else if (room_data) begin
            push     = 1'b1;
            wr_entry = '{user: 1'b0, last: 1'b0, data: gem_rx_w_data};
          end else begin
            state_d = ST_DROP;
          end
        end
      end
      ST_DROP: begin
        if (gem_rx_w_flush || (gem_rx_w_wr && gem_rx_w_eop)) begin
          push    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DISCARD: begin
        if (gem_rx_w_flush || (gem_rx_w_wr && gem_rx_w_eop)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Buffer bookkeeping and next head-of-queue (bypasses the array when writing into empty).
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    if (count_d == '0) begin
      head_d = '0;
    end else if (push && (wr_ptr_q == rd_ptr_d)) begin
      head_d = wr_entry;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  // State, pointers and registered stream outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      valid_q  <= (count_d != '0);
      ovf_q    <= (state_d == ST_DROP);
    end
  end

  // Buffer storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  assign m_axis_tdata      = head_q.data;
  assign m_axis_tlast      = head_q.last;
  assign m_axis_tuser      = head_q.user;
  assign m_axis_tvalid     = valid_q;
  assign gem_rx_w_overflow = ovf_q;

`ifdef GEM_EXT_FIFO_RX_STATUS_EN
  logic [44:0] status_q;
  logic        status_valid_q;

  // Status word latched with each accepted end-of-frame byte.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      status_q       <= '0;
      status_valid_q <= 1'b0;
    end else begin
      status_valid_q <= eop_accept;
      if (eop_accept) begin
        status_q <= gem_rx_w_status;
      end
    end
  end

  assign rx_status       = status_q;
  assign rx_status_valid = status_valid_q;
`else
  logic unused_eop_accept;
  assign unused_eop_accept = eop_accept;
`endif

endmodule

// File: tb/tb_gem_ext_fifo_rx.sv
`timescale 1ns/1ps
// Bench for gem_ext_fifo_rx: directed scenarios plus randomized frames, checked each
// cycle against a frame-level reference model (queue of expected output beats).
module tb_gem_ext_fifo_rx;

  localparam int DEPTH = 16;

  logic       clk;
  logic       rstn;
  logic [7:0] w_data;
  logic       w_wr, w_sop, w_eop, w_err, w_flush;
  logic       ovf;
  logic [7:0] tdata;
  logic       tvalid, tready, tlast, tuser;

  gem_ext_fifo_rx #(.DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rstn              (rstn),
    .gem_rx_w_data     (w_data),
    .gem_rx_w_wr       (w_wr),
    .gem_rx_w_sop      (w_sop),
    .gem_rx_w_eop      (w_eop),
    .gem_rx_w_err      (w_err),
    .gem_rx_w_flush    (w_flush),
    .gem_rx_w_overflow (ovf),
    .m_axis_tdata      (tdata),
    .m_axis_tvalid     (tvalid),
    .m_axis_tready     (tready),
    .m_axis_tlast      (tlast),
    .m_axis_tuser      (tuser)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int beats  = 0;
  int mode   = 1;   // 0: tready low, 1: tready high, 2: random

  // Reference model: expected beats {user,last,data} plus frame-level status flags.
  logic [9:0] expq[$];
  bit in_frame;     // bytes of the current frame have been queued, no tlast yet
  bit skipping;     // ignoring GEM bytes until the frame ends
  bit owe_term;     // while skipping: a bad-frame terminator must be queued at the end
  logic exp_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    expq.delete();
    in_frame = 0;
    skipping = 0;
    owe_term = 0;
    exp_ovf  = 1'b0;
  endtask

  // One clock: check outputs, drive this cycle's inputs, advance the model.
  task automatic step(input logic wr, input logic sop, input logic eop, input logic er,
                      input logic fl, input logic [7:0] d);
    int   occ;
    logic rdy;
    logic [9:0] term;
    term = 10'h300;
    @(negedge clk);
    chk("tvalid", tvalid, (expq.size() != 0));
    if (expq.size() != 0) chk("beat", {tuser, tlast, tdata}, expq[0]);
    chk("overflow", ovf, exp_ovf);
    rdy = (mode == 1) ? 1'b1 : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    w_wr = wr; w_sop = sop; w_eop = eop; w_err = er; w_flush = fl; w_data = d;
    tready = rdy;

    occ = expq.size();
    if (occ != 0 && rdy) begin
      void'(expq.pop_front());
      beats++;
    end
    if (fl) begin
      if (in_frame || (skipping && owe_term)) expq.push_back(term);
      in_frame = 0; skipping = 0; owe_term = 0;
    end else if (wr) begin
      if (skipping) begin
        if (eop) begin
          if (owe_term) expq.push_back(term);
          skipping = 0; owe_term = 0;
        end
      end else if (!in_frame) begin
        if (sop) begin
          if (eop) begin
            if (occ < DEPTH) expq.push_back({er, 1'b1, d});
          end else if (occ < DEPTH - 1) begin
            expq.push_back({2'b00, d});
            in_frame = 1;
          end else begin
            skipping = 1; owe_term = 0;
          end
        end
      end else begin
        if (sop) begin
          expq.push_back({2'b11, d});
          in_frame = 0; skipping = !eop; owe_term = 0;
        end else if (eop) begin
          expq.push_back({er, 1'b1, d});
          in_frame = 0;
        end else if (occ < DEPTH - 1) begin
          expq.push_back({2'b00, d});
        end else begin
          in_frame = 0; skipping = 1; owe_term = 1;
        end
      end
    end
    exp_ovf = skipping && owe_term;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 8'h00);
  endtask

  task automatic send(input int len, input logic er, input bit with_eop, input bit rnd);
    for (int i = 0; i < len; i++)
      step(1, 1'(i == 0), 1'(with_eop && (i == len - 1)), er, 0,
           rnd ? 8'($urandom) : 8'(i));
  endtask

  task automatic drain();
    int n;
    n = 0;
    mode = 1;
    while (expq.size() != 0 && n < 300) begin
      idle();
      n++;
    end
    idle();
    chk("drain_left", expq.size(), 0);
  endtask

  int   len, fl_at;
  bit   noeop;
  logic er;

  initial begin
    rstn = 1'b0; w_wr = 0; w_sop = 0; w_eop = 0; w_err = 0; w_flush = 0; w_data = '0;
    tready = 1'b1;
    model_clear();
    repeat (3) @(negedge clk);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_tuser", tuser, 0);
    chk("rst_ovf", ovf, 0);
    rstn = 1'b1;

    // Good 64-byte frame, streaming through.
    mode = 1; beats = 0;
    send(64, 0, 1, 0);
    drain();
    chk("t1_beats", beats, 64);

    // Same frame with err at eop.
    beats = 0;
    send(64, 1, 1, 0);
    drain();
    chk("t2_beats", beats, 64);

    // Overflow with sink stalled: 15 data bytes + terminator.
    mode = 0; beats = 0;
    send(40, 0, 1, 0);
    repeat (3) idle();
    chk("t3_ovf_after", ovf, 0);
    drain();
    chk("t3_beats", beats, 16);

    // Missing eop: A closed by B's first byte, B discarded, next frame clean.
    mode = 1; beats = 0;
    send(10, 0, 0, 0);
    send(6, 0, 1, 1);
    drain();
    chk("t4_beats", beats, 11);
    beats = 0;
    send(8, 0, 1, 1);
    drain();
    chk("t4_good_beats", beats, 8);

    // Flush mid-frame, then flush while idle.
    beats = 0;
    send(5, 0, 0, 0);
    step(0, 0, 0, 0, 1, 8'h00);
    drain();
    chk("t5_beats", beats, 6);
    beats = 0;
    repeat (3) step(0, 0, 0, 0, 1, 8'h00);
    drain();
    chk("t5_idle_flush_beats", beats, 0);

    // Reset mid-frame with data buffered.
    mode = 0;
    send(6, 0, 0, 1);
    @(negedge clk);
    rstn = 1'b0;
    w_wr = 0; w_sop = 0; w_eop = 0; w_flush = 0;
    #1;
    chk("t6_tvalid_in_reset", tvalid, 0);
    chk("t6_ovf_in_reset", ovf, 0);
    model_clear();
    repeat (2) idle();
    rstn = 1'b1;
    mode = 1; beats = 0;
    send(12, 0, 1, 1);
    drain();
    chk("t6_beats", beats, 12);

    // Randomized frames, random backpressure, occasional flush or missing eop.
    mode = 2;
    for (int f = 0; f < 60; f++) begin
      len   = $urandom_range(1, 40);
      fl_at = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len - 1) : -1;
      noeop = ($urandom_range(0, 9) == 0);
      er    = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < len; i++) begin
        if (i == fl_at) begin
          step(0, 0, 0, 0, 1, 8'h00);
          break;
        end
        step(1, 1'(i == 0), 1'((i == len - 1) && !noeop), er, 0, 8'($urandom));
      end
      repeat ($urandom_range(0, 3)) idle();
    end
    drain();
    chk("end_tvalid", tvalid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
